// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit with architectural HI/LO registers.
// One radix-2 step per cycle: 1 accept edge, 32 CALC edges, 1 FIX edge.
module muldiv_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    input  logic        flush,
    input  logic        hilo_req,
    output logic        busy,
    output logic        stall,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [4:0]  count;
    logic        is_div;
    logic        neg_q;
    logic        neg_r;
    logic        div_zero;
    logic [31:0] a_raw;
    logic [31:0] b_mag;
    logic [63:0] acc;

    logic        accept;
    logic        signed_op;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag_in;
    logic [31:0] b_mag_in;

    logic [32:0] mul_sum;
    logic [63:0] mul_step;
    logic [32:0] rem_sh;
    logic        div_ge;
    logic [31:0] rem_new;
    logic [63:0] div_step;

    logic [63:0] product;
    logic [31:0] quot;
    logic [31:0] rem;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    assign busy  = (state != IDLE);
    assign stall = hilo_req & busy;

    // A flush in IDLE suppresses a coincident start.
    assign accept    = (state == IDLE) && start && !flush;
    assign signed_op = ~op[0];
    assign a_neg     = signed_op & src_a[31];
    assign b_neg     = signed_op & src_b[31];
    assign a_mag_in  = a_neg ? (~src_a + 32'd1) : src_a;
    assign b_mag_in  = b_neg ? (~src_b + 32'd1) : src_b;

    // Multiply: acc = {partial, multiplier}; add on LSB, then shift right.
    assign mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, b_mag} : 33'd0);
    assign mul_step = {mul_sum, acc[31:1]};

    // Restoring divide: acc = {remainder, dividend/quotient}; shift left, trial subtract.
    assign rem_sh   = acc[63:31];
    assign div_ge   = rem_sh[32] | (rem_sh[31:0] >= b_mag);
    assign rem_new  = rem_sh[31:0] - b_mag;
    assign div_step = {div_ge ? rem_new : rem_sh[31:0], acc[30:0], div_ge};

    assign product = neg_q ? (~acc + 64'd1) : acc;
    assign quot    = acc[31:0];
    assign rem     = acc[63:32];

    always_comb begin
        // NOTE: every output gets a default first so no latch is inferred.
        res_hi = product[63:32];
        res_lo = product[31:0];
        if (is_div) begin
            if (div_zero) begin
                res_hi = a_raw;
                res_lo = 32'hFFFF_FFFF;
            end else begin
                res_lo = neg_q ? (~quot + 32'd1) : quot;
                res_hi = neg_r ? (~rem + 32'd1) : rem;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = CALC;
            CALC: begin
                if (flush)               state_next = IDLE;
                else if (count == 5'd31) state_next = FIX;
            end
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count    <= 5'd0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            a_raw    <= 32'd0;
            b_mag    <= 32'd0;
            acc      <= 64'd0;
            hi       <= 32'd0;
            lo       <= 32'd0;
            done     <= 1'b0;
        end else begin
            done <= (state == FIX) && !flush;
            case (state)
                IDLE: begin
                    count <= 5'd0;
                    if (accept) begin
                        is_div   <= op[1];
                        neg_q    <= a_neg ^ b_neg;
                        neg_r    <= a_neg;
                        div_zero <= (src_b == 32'd0);
                        a_raw    <= src_a;
                        b_mag    <= b_mag_in;
                        acc      <= {32'd0, a_mag_in};
                    end else if (!start) begin
                        // mthi/mtlo only land when no operation is being launched.
                        if (hi_we) hi <= wdata;
                        if (lo_we) lo <= wdata;
                    end
                end
                CALC: begin
                    count <= count + 5'd1;
                    acc   <= is_div ? div_step : mul_step;
                end
                FIX: begin
                    count <= 5'd0;
                    if (!flush) begin
                        hi <= res_hi;
                        lo <= res_lo;
                    end
                end
                default: count <= 5'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: cycle-level behavioural model plus
// directed literal cases and a randomized phase.
module tb_muldiv_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        flush;
    logic        hilo_req;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;

    muldiv_unit dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .src_a    (src_a),
        .src_b    (src_b),
        .hi_we    (hi_we),
        .lo_we    (lo_we),
        .wdata    (wdata),
        .flush    (flush),
        .hilo_req (hilo_req),
        .busy     (busy),
        .stall    (stall),
        .done     (done),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Architectural result {hi, lo} computed with plain integer arithmetic.
    function automatic logic [63:0] model_result(input logic [1:0] o, input logic [31:0] a,
                                                 input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] ua;
        logic [63:0] ub;
        logic [63:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (o)
            2'b00: res = 64'(sa * sb);
            2'b01: res = ua * ub;
            default: begin
                if (b == 32'd0) begin
                    res = {a, 32'hFFFF_FFFF};
                end else if (o == 2'b10) begin
                    q   = sa / sb;
                    r   = sa % sb;
                    res = {32'(r), 32'(q)};
                end else begin
                    res = {32'(ua % ub), 32'(ua / ub)};
                end
            end
        endcase
        return res;
    endfunction

    // Cycle-level model: a busy countdown and a pending result.
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic [31:0] p_hi;
    logic [31:0] p_lo;
    logic [63:0] m_res;
    int          m_left;
    bit          m_done;
    bit          m_nd;

    initial begin
        m_hi = 0; m_lo = 0; p_hi = 0; p_lo = 0; m_left = 0; m_done = 0;
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_hi   = 32'd0;
            m_lo   = 32'd0;
            m_left = 0;
            m_done = 1'b0;
        end else begin
            m_nd = 1'b0;
            if (m_left == 0) begin
                if (start && !flush) begin
                    m_res  = model_result(op, src_a, src_b);
                    p_hi   = m_res[63:32];
                    p_lo   = m_res[31:0];
                    m_left = 33;
                end else if (!start) begin
                    if (hi_we) m_hi = wdata;
                    if (lo_we) m_lo = wdata;
                end
            end else if (flush) begin
                m_left = 0;
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_hi = p_hi;
                    m_lo = p_lo;
                    m_nd = 1'b1;
                end
            end
            m_done = m_nd;
        end
    end

    always @(negedge clk) begin
        check("busy",  busy,  m_left != 0);
        check("done",  done,  m_done);
        check("stall", stall, hilo_req && (m_left != 0));
        check("hi",    hi,    m_hi);
        check("lo",    lo,    m_lo);
    end

    int n_done_seen = 0;
    always @(negedge clk) if (done) n_done_seen++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        tick();
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(output int n_busy, output int n_stall, output bit seen);
        n_busy  = 0;
        n_stall = 0;
        seen    = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
            end else begin
                if (busy)  n_busy++;
                if (stall) n_stall++;
            end
        end
    endtask

    task automatic run_directed(input string name, input logic [1:0] o, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] exp_hi,
                                input logic [31:0] exp_lo);
        int nb;
        int ns;
        bit seen;
        launch(o, a, b);
        wait_done(nb, ns, seen);
        check({name, "_done_seen"}, seen, 1'b1);
        check({name, "_latency"},   nb, 33);
        check({name, "_hi"},        hi, exp_hi);
        check({name, "_lo"},        lo, exp_lo);
        @(negedge clk);
        check({name, "_done_pulse"}, done, 1'b0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            4:       return 32'($urandom_range(0, 20));
            5:       return 32'(-int'($urandom_range(1, 20)));
            default: return $urandom();
        endcase
    endfunction

    initial begin
        int nb;
        int ns;
        int nd;
        bit seen;

        reset = 1'b0; start = 1'b0; op = 2'b00; src_a = 0; src_b = 0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = 0; flush = 1'b0; hilo_req = 1'b1;

        // Reset state, then start on the very edge after release.
        repeat (2) tick();
        check("rst_busy",  busy,  1'b0);
        check("rst_done",  done,  1'b0);
        check("rst_stall", stall, 1'b0);
        check("rst_hi",    hi,    32'd0);
        check("rst_lo",    lo,    32'd0);
        hilo_req = 1'b0;
        reset = 1'b1;
        start = 1'b1; op = 2'b01; src_a = 32'hFFFF_FFFF; src_b = 32'hFFFF_FFFF;
        tick();
        start = 1'b0;
        wait_done(nb, ns, seen);
        check("multu_max_seen",    seen, 1'b1);
        check("multu_max_latency", nb,   33);
        check("multu_max_hi",      hi,   32'hFFFF_FFFE);
        check("multu_max_lo",      lo,   32'h0000_0001);
        @(negedge clk);
        check("multu_max_pulse",   done, 1'b0);

        run_directed("mult_m3x5",  2'b00, 32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_directed("div_m7d2",   2'b10, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_directed("divu_by0",   2'b11, 32'd100,       32'd0,        32'h0000_0064, 32'hFFFF_FFFF);
        run_directed("div_by0",    2'b10, 32'hFFFF_FFF0, 32'd0,        32'hFFFF_FFF0, 32'hFFFF_FFFF);
        run_directed("div_ovf",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        run_directed("divu_big",   2'b11, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF);

        // Stall window with a second start at cycle 5 that must be ignored.
        hilo_req = 1'b1;
        launch(2'b10, 32'd1000, 32'd7);
        ns = 0;
        seen = 1'b0;
        for (int c = 1; c <= 60 && !seen; c++) begin
            if (c == 5) begin
                start = 1'b1; op = 2'b00; src_a = 32'd2; src_b = 32'd3;
            end
            if (c == 6) start = 1'b0;
            @(negedge clk);
            if (done) seen = 1'b1;
            else if (stall) ns++;
            if (!seen) tick();
        end
        check("stall_seen",      seen,  1'b1);
        check("stall_cycles",    ns,    33);
        check("stall_done_zero", stall, 1'b0);
        check("stall_div_lo",    lo,    32'd142);
        check("stall_div_hi",    hi,    32'd6);
        tick();
        start = 1'b0;
        hilo_req = 1'b0;

        // mthi, then flush a multiply at cycle 10.
        hi_we = 1'b1; wdata = 32'h1234_5678;
        tick();
        hi_we = 1'b0;
        check("mthi_hi", hi, 32'h1234_5678);
        launch(2'b00, 32'd7, 32'd9);
        repeat (8) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_busy", busy, 1'b0);
        check("flush_hi",   hi,   32'h1234_5678);
        nd = n_done_seen;
        repeat (40) tick();
        check("flush_no_done", n_done_seen - nd, 0);

        // Asynchronous reset in the middle of a multiply.
        hilo_req = 1'b1;
        launch(2'b00, 32'hFFFF_FFFD, 32'd5);
        repeat (18) tick();
        #2;
        reset = 1'b0;
        #1;
        check("midrst_busy",  busy,  1'b0);
        check("midrst_done",  done,  1'b0);
        check("midrst_stall", stall, 1'b0);
        check("midrst_hi",    hi,    32'd0);
        check("midrst_lo",    lo,    32'd0);
        repeat (2) tick();
        reset = 1'b1;
        nd = n_done_seen;
        repeat (40) tick();
        check("midrst_no_done", n_done_seen - nd, 0);
        check("midrst_hi_kept", hi, 32'd0);

        // Randomized traffic checked every cycle by the model.
        nd = n_done_seen;
        for (int i = 0; i < 5000; i++) begin
            tick();
            start    = ($urandom_range(0, 3) == 0);
            op       = 2'($urandom_range(0, 3));
            src_a    = pick();
            src_b    = pick();
            hi_we    = ($urandom_range(0, 7) == 0);
            lo_we    = ($urandom_range(0, 7) == 0);
            wdata    = $urandom();
            flush    = ($urandom_range(0, 79) == 0);
            hilo_req = 1'($urandom_range(0, 1));
        end
        tick();
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0; flush = 1'b0; hilo_req = 1'b0;
        repeat (40) tick();
        check("random_done_count", (n_done_seen - nd) >= 40, 1'b1);
        check("random_idle_end",   busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
